ctrl_st: RTL and testbench
==========================

Name: ctrl_st

Overview:
- Store-side tile controller: the read/drain counterpart of the tile load controller.
- After a compute tile, reads the LUT (bit-serial, BS) array output buffer and then the DSP (bit-parallel, BP) array output buffer, sequentially from address 0.
- Streams the words out on a valid/ready interface toward the DMA/writeback path.
- Absorbs the 1-cycle buffer read latency with a 2-entry output FIFO, so backpressure never drops or duplicates a word.

Parameters:
- DATA_W, 32, width of one output-buffer word and of st_data.
- OUT_BUF_AW, 9, output-buffer address width in bits.
- RD_LAT, 1, buffer read latency in cycles; only 1 is supported and it is checked by elaboration assertion.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- bs_st_times  in  16  number of BS words to drain; latched on an accepted st_tile_start.
- bp_st_times  in  16  number of BP words to drain; latched on an accepted st_tile_start.
- st_tile_start  in  1  one-cycle start pulse.
- st_busy  out  1  high from the accepted start through the st_tile_end cycle.
- bs_out_buf_rd_en  out  1  BS buffer read enable.
- bs_out_buf_rd_addr  out  OUT_BUF_AW  BS buffer read address.
- bs_out_buf_rd_data  in  DATA_W  BS read data, valid RD_LAT cycles after rd_en.
- bp_out_buf_rd_en  out  1  BP buffer read enable.
- bp_out_buf_rd_addr  out  OUT_BUF_AW  BP buffer read address.
- bp_out_buf_rd_data  in  DATA_W  BP read data, valid RD_LAT cycles after rd_en.
- st_data  out  DATA_W  stream data (FIFO head).
- st_valid  out  1  stream valid.
- st_ready  in  1  stream ready.
- st_last  out  1  marks the final beat of the tile.
- st_tile_end  out  1  one-cycle pulse when the tile drain is complete.

Behaviour:
Reset values:
- All outputs 0; state IDLE; counters 0; FIFO empty; the in-flight flag cleared.
- Reset mid-tile aborts the tile: no st_tile_end, and the FIFO contents are discarded.

State machine (IDLE, RD_BS, RD_BP, DRAIN):
- In IDLE, st_tile_start latches both counts. Next state:
  - RD_BS if bs_st_times≠0;
  - else RD_BP if bp_st_times≠0;
  - else DRAIN.
- st_tile_start outside IDLE is ignored; the latched counts are unchanged.
- RD_BS: issue BS reads at addresses 0..bs_st_times-1. After the last issue, go to RD_BP (or DRAIN if the BP count is 0).
- RD_BP: issue BP reads at addresses 0..bp_st_times-1. After the last issue, go to DRAIN.
- DRAIN: wait until the FIFO is empty, nothing is in flight, and the final beat has handshaken. Then pulse st_tile_end for one cycle and return to IDLE.
- Zero-count tile: DRAIN is entered with no beats, and st_tile_end pulses 2 cycles after st_tile_start.

Read issue rule:
- Issue (rd_en=1) only when (fifo_occ + inflight − pop) < 2, where pop = st_valid & st_ready in the same cycle.
- The address counter is 16-bit internally; the low OUT_BUF_AW bits drive rd_addr. It is cleared on each phase entry.
- Only one of the two rd_en outputs is high in any cycle. rd_addr holds its value when rd_en=0.

Data path:
- Returned read data is written into the FIFO in the cycle after rd_en, together with a last flag.
- The last flag is set for the final BP word, or for the final BS word when bp_st_times=0.
- st_data, st_valid and st_last come from the FIFO head. st_valid depends only on FIFO occupancy (no combinational path from st_ready).

Latency and throughput:
- Start accepted at cycle T → first rd_en at T+1 → st_valid at T+3 (FIFO write at T+2).
- With st_ready held at 1: one beat per cycle, no bubbles between the BS and BP phases.

Handshake and backpressure:
- While st_valid=1 and st_ready=0, st_data and st_last are held stable.
- The FIFO never overflows; the issue rule guarantees this.

Completion:
- st_tile_end is asserted the cycle after the handshake of the st_last beat.
- st_busy falls in the cycle after st_tile_end.

Test Plan:
- bs=3, bp=2, st_ready=1 → BS addrs 0,1,2 then BP addrs 0,1 on consecutive cycles; 5 beats in order; st_last on beat 5 only; st_tile_end one cycle later.
- bs=4, bp=4, st_ready toggled randomly (50%) → exactly 8 beats, no loss or duplicate; data stable while stalled; FIFO occupancy never exceeds 2.
- bs=0, bp=3 → no bs rd_en; st_last on the 3rd BP beat. Also bs=2, bp=0 → st_last on the 2nd BS beat.
- bs=0, bp=0 → no beats; st_tile_end pulses at T+2; st_busy high T+1..T+2.
- st_tile_start pulsed mid-tile with different counts → ignored; the original beat count completes; exactly one st_tile_end.
- rst_n low for 1 cycle mid-RD_BP with st_ready=0 → all outputs 0 next cycle; a new start then produces a clean tile from BS address 0.

Source files
------------

// File: rtl/ctrl_st.sv
// Store-side tile controller: drains the BS then BP output buffers from address 0
// and streams the words out through a 2-entry FIFO on a valid/ready interface.
module ctrl_st #(
    parameter int DATA_W     = 32,
    parameter int OUT_BUF_AW = 9,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           bs_st_times,
    input  logic [15:0]           bp_st_times,
    input  logic                  st_tile_start,
    output logic                  st_busy,
    output logic                  bs_out_buf_rd_en,
    output logic [OUT_BUF_AW-1:0] bs_out_buf_rd_addr,
    input  logic [DATA_W-1:0]     bs_out_buf_rd_data,
    output logic                  bp_out_buf_rd_en,
    output logic [OUT_BUF_AW-1:0] bp_out_buf_rd_addr,
    input  logic [DATA_W-1:0]     bp_out_buf_rd_data,
    output logic [DATA_W-1:0]     st_data,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic                  st_last,
    output logic                  st_tile_end
);

    generate
        if (RD_LAT != 1) begin : g_rd_lat_check
            $error("ctrl_st: only RD_LAT == 1 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RD_BS, RD_BP, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [15:0]         bs_times_q, bp_times_q;
    logic [15:0]         bs_cnt, bp_cnt;
    logic                inflight, inflight_bp, inflight_last;
    logic [DATA_W:0]     fifo_mem [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          occ;
    logic                pop, room, head_last;
    logic                bs_issue, bp_issue, bs_final, bp_final;
    logic                drain_done, tile_end_q;

    assign st_valid  = (occ != 2'd0);
    assign pop       = st_valid & st_ready;
    assign head_last = fifo_mem[rd_ptr][DATA_W];
    // Counting the in-flight read keeps the FIFO from ever needing a third slot.
    assign room      = ({1'b0, occ} + {2'b00, inflight} - {2'b00, pop}) < 3'd2;
    assign bs_final  = (bs_cnt == bs_times_q - 16'd1);
    assign bp_final  = (bp_cnt == bp_times_q - 16'd1);

    always_comb begin
        state_nxt  = state;
        bs_issue   = 1'b0;
        bp_issue   = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (st_tile_start) begin
                    if (bs_st_times != 16'd0)      state_nxt = RD_BS;
                    else if (bp_st_times != 16'd0) state_nxt = RD_BP;
                    else                           state_nxt = DRAIN;
                end
            end
            RD_BS: begin
                if (room) begin
                    bs_issue = 1'b1;
                    if (bs_final) state_nxt = (bp_times_q != 16'd0) ? RD_BP : DRAIN;
                end
            end
            RD_BP: begin
                if (room) begin
                    bp_issue = 1'b1;
                    if (bp_final) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Done when the only thing left is the last beat handshaking now.
                if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop && head_last))) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bs_times_q    <= '0;
            bp_times_q    <= '0;
            bs_cnt        <= '0;
            bp_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_bp   <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            occ           <= '0;
            tile_end_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tile_end_q <= drain_done;
            if (state == IDLE && st_tile_start) begin
                bs_times_q <= bs_st_times;
                bp_times_q <= bp_st_times;
            end
            if (state_nxt == RD_BS && state != RD_BS) bs_cnt <= '0;
            else if (bs_issue)                        bs_cnt <= bs_cnt + 16'd1;
            if (state_nxt == RD_BP && state != RD_BP) bp_cnt <= '0;
            else if (bp_issue)                        bp_cnt <= bp_cnt + 16'd1;
            inflight      <= bs_issue | bp_issue;
            inflight_bp   <= bp_issue;
            inflight_last <= bs_issue ? (bs_final && bp_times_q == 16'd0) : (bp_issue && bp_final);
            if (inflight) wr_ptr <= ~wr_ptr;
            if (pop)      rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (inflight)
            fifo_mem[wr_ptr] <= {inflight_last, inflight_bp ? bp_out_buf_rd_data : bs_out_buf_rd_data};
    end

    assign bs_out_buf_rd_en   = bs_issue;
    assign bp_out_buf_rd_en   = bp_issue;
    assign bs_out_buf_rd_addr = bs_cnt[OUT_BUF_AW-1:0];
    assign bp_out_buf_rd_addr = bp_cnt[OUT_BUF_AW-1:0];
    // Head is masked when empty so stale entries never show on the stream.
    assign st_data     = st_valid ? fifo_mem[rd_ptr][DATA_W-1:0] : '0;
    assign st_last     = st_valid & head_last;
    assign st_tile_end = tile_end_q;
    assign st_busy     = (state != IDLE) | tile_end_q;

endmodule

// File: tb/tb_ctrl_st.sv
// Randomized bench for ctrl_st: buffer models, a beat scoreboard built from the tile
// counts, and a negedge monitor that checks reads, beats, stalls and completion timing.
module tb_ctrl_st;
    localparam int DATA_W = 32;
    localparam int AW     = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       bs_st_times = '0;
    logic [15:0]       bp_st_times = '0;
    logic              st_tile_start = 1'b0;
    logic              st_busy;
    logic              bs_out_buf_rd_en, bp_out_buf_rd_en;
    logic [AW-1:0]     bs_out_buf_rd_addr, bp_out_buf_rd_addr;
    logic [DATA_W-1:0] bs_out_buf_rd_data = '0;
    logic [DATA_W-1:0] bp_out_buf_rd_data = '0;
    logic [DATA_W-1:0] st_data;
    logic              st_valid, st_last, st_tile_end;
    logic              st_ready = 1'b0;

    ctrl_st #(.DATA_W(DATA_W), .OUT_BUF_AW(AW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .bs_st_times(bs_st_times), .bp_st_times(bp_st_times),
        .st_tile_start(st_tile_start), .st_busy(st_busy),
        .bs_out_buf_rd_en(bs_out_buf_rd_en), .bs_out_buf_rd_addr(bs_out_buf_rd_addr),
        .bs_out_buf_rd_data(bs_out_buf_rd_data),
        .bp_out_buf_rd_en(bp_out_buf_rd_en), .bp_out_buf_rd_addr(bp_out_buf_rd_addr),
        .bp_out_buf_rd_data(bp_out_buf_rd_data),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_last(st_last), .st_tile_end(st_tile_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output buffers with one cycle of read latency; junk on idle cycles.
    logic [DATA_W-1:0] bs_mem [512];
    logic [DATA_W-1:0] bp_mem [512];
    always @(posedge clk) begin
        bs_out_buf_rd_data <= bs_out_buf_rd_en ? bs_mem[bs_out_buf_rd_addr] : DATA_W'($urandom());
        bp_out_buf_rd_data <= bp_out_buf_rd_en ? bp_mem[bp_out_buf_rd_addr] : DATA_W'($urandom());
    end

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       st_ready = 1'b1;
            1:       st_ready = 1'($urandom_range(0, 1));
            default: st_ready = 1'b0;
        endcase
    end

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] exp_q [$];
    int exp_bs_addr, exp_bp_addr, bs_issued, bp_issued, popped;
    int tile_end_cnt = 0;
    int exp_end_cyc  = -1;
    int start_cyc, te_before;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, independent of the stimulus.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            logic [DATA_W:0] e;
            logic [AW-1:0] a;
            if (bs_out_buf_rd_en || bp_out_buf_rd_en)
                check("rd_en_onehot", longint'(bs_out_buf_rd_en && bp_out_buf_rd_en), 0);
            if (bs_out_buf_rd_en) begin
                a = exp_bs_addr[AW-1:0];
                check("bs_rd_addr", bs_out_buf_rd_addr, a);
                exp_bs_addr++;
                bs_issued++;
            end
            if (bp_out_buf_rd_en) begin
                a = exp_bp_addr[AW-1:0];
                check("bp_rd_addr", bp_out_buf_rd_addr, a);
                exp_bp_addr++;
                bp_issued++;
            end
            if (prev_stall) begin
                check("stall_valid", st_valid, 1);
                check("stall_data", st_data, prev_data);
                check("stall_last", st_last, prev_last);
            end
            if (st_valid && st_ready) begin
                popped++;
                check("beat_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", st_data, e[DATA_W-1:0]);
                    check("beat_last", st_last, e[DATA_W]);
                    if (e[DATA_W]) exp_end_cyc = cyc + 1;
                end
            end
            if (bs_out_buf_rd_en || bp_out_buf_rd_en || (st_valid && st_ready))
                check("outstanding_le_2", longint'(bs_issued + bp_issued - popped <= 2), 1);
            if (st_tile_end) begin
                tile_end_cnt++;
                check("tile_end_cycle", cyc, exp_end_cyc);
                exp_end_cyc = -1;
            end
            prev_stall = st_valid && !st_ready;
            prev_data  = st_data;
            prev_last  = st_last;
        end
    end

    // Starts a tile and fills the scoreboard with the beats the tile must produce.
    task automatic applyStimulus(input int b, input int p);
        logic [DATA_W:0] e;
        @(posedge clk); #1;
        bs_st_times   = 16'(b);
        bp_st_times   = 16'(p);
        st_tile_start = 1'b1;
        start_cyc     = cyc;
        te_before     = tile_end_cnt;
        exp_bs_addr = 0; exp_bp_addr = 0;
        bs_issued = 0; bp_issued = 0; popped = 0;
        for (int i = 0; i < b; i++) begin
            e = {(p == 0 && i == b - 1), bs_mem[i]};
            exp_q.push_back(e);
        end
        for (int i = 0; i < p; i++) begin
            e = {(i == p - 1), bp_mem[i]};
            exp_q.push_back(e);
        end
        exp_end_cyc = (b + p == 0) ? start_cyc + 2 : -1;
        @(posedge clk); #1;
        st_tile_start = 1'b0;
        bs_st_times   = 16'($urandom());
        bp_st_times   = 16'($urandom());
    endtask

    // Waits (bounded) for completion, then checks totals and a single end pulse.
    task automatic checkOutput(input int b, input int p);
        int n = 0;
        while (tile_end_cnt == te_before && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tile_end_seen", longint'(tile_end_cnt != te_before), 1);
        repeat (6) @(negedge clk);
        check("tile_end_count", tile_end_cnt - te_before, 1);
        check("beats_left", exp_q.size(), 0);
        check("bs_reads", bs_issued, b);
        check("bp_reads", bp_issued, p);
        check("busy_after_tile", st_busy, 0);
        exp_q.delete();
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, "_busy"}, st_busy, 0);
        check({tag, "_bs_rd_en"}, bs_out_buf_rd_en, 0);
        check({tag, "_bp_rd_en"}, bp_out_buf_rd_en, 0);
        check({tag, "_bs_addr"}, bs_out_buf_rd_addr, 0);
        check({tag, "_bp_addr"}, bp_out_buf_rd_addr, 0);
        check({tag, "_valid"}, st_valid, 0);
        check({tag, "_data"}, st_data, 0);
        check({tag, "_last"}, st_last, 0);
        check({tag, "_tile_end"}, st_tile_end, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) begin
            bs_mem[i] = DATA_W'($urandom());
            bp_mem[i] = DATA_W'($urandom());
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkZeroOutputs("reset");

        $display("[TB] directed tile bs=3 bp=2, ready held high");
        applyStimulus(3, 2);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("rd_issue_T%0d", k), longint'(bs_out_buf_rd_en || bp_out_buf_rd_en), longint'(k <= 5));
            check($sformatf("valid_T%0d", k), st_valid, longint'(k >= 3));
        end
        checkOutput(3, 2);

        $display("[TB] bs=4 bp=4 with random backpressure");
        ready_mode = 1;
        applyStimulus(4, 4);
        checkOutput(4, 4);

        $display("[TB] single-phase tiles");
        ready_mode = 0;
        applyStimulus(0, 3);
        checkOutput(0, 3);
        applyStimulus(2, 0);
        checkOutput(2, 0);

        $display("[TB] zero-count tile");
        applyStimulus(0, 0);
        @(negedge clk);
        check("zero_busy_T1", st_busy, 1);
        check("zero_end_T1", st_tile_end, 0);
        @(negedge clk);
        check("zero_busy_T2", st_busy, 1);
        check("zero_end_T2", st_tile_end, 1);
        @(negedge clk);
        check("zero_busy_T3", st_busy, 0);
        checkOutput(0, 0);

        $display("[TB] start pulsed mid-tile");
        ready_mode = 1;
        applyStimulus(4, 4);
        repeat (2) @(posedge clk);
        #1;
        bs_st_times = 16'd1; bp_st_times = 16'd1; st_tile_start = 1'b1;
        @(posedge clk); #1 st_tile_start = 1'b0;
        checkOutput(4, 4);

        $display("[TB] random tiles");
        for (int it = 0; it < 5; it++) begin
            int b = $urandom_range(0, 7);
            int p = $urandom_range(0, 7);
            applyStimulus(b, p);
            checkOutput(b, p);
        end

        $display("[TB] reset during BP phase under backpressure");
        ready_mode = 0;
        applyStimulus(2, 6);
        n = 0;
        while (!bp_out_buf_rd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_bp_phase", bp_out_buf_rd_en, 1);
        ready_mode = 2;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkZeroOutputs("midreset");
        exp_q.delete();
        exp_end_cyc = -1;
        te_before = tile_end_cnt;
        repeat (5) @(negedge clk);
        check("no_end_after_reset", tile_end_cnt, te_before);
        ready_mode = 0;
        applyStimulus(2, 1);
        checkOutput(2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
